ysyx_23060203_issue_sb: RTL and testbench
=========================================

// Module: ysyx_23060203_issue_sb
// PURPOSE
//  Issue scoreboard between IDU and EXU. Tracks GPR and CSR writes issued to EXU but not yet retired (multi-cycle
//  LSU loads, MUL/DIV), and blocks the IDU->EXU handshake while an operand depends on one of them.
//  Complements the single-stage EXU bypass, which covers only the instruction currently in EXU.
//  Also bounds total in-flight instructions.
// PARAMETERS
//  MAX_INFLIGHT  4  max issued-but-unretired instructions (1..15)
//  CNT_W         2  width of per-GPR pending counter; saturation (2**CNT_W-1) blocks a further WAW issue
// PORTS
//  clock        in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  idu_valid    in   1   IDU has a decoded instruction
//  idu_ready    out  1   scoreboard+EXU accept it (to IDU out_ready)
//  exu_valid    out  1   forwarded valid to EXU
//  exu_ready    in   1   EXU can accept
//  flush        in   1   redirect; current IDU instruction must not issue
//  rs1/rs2      in   5   source register indices of IDU instruction
//  rs1_use/rs2_use in 1  source actually read
//  rd           in   5   destination (0 = no write)
//  csr_raddr    in   12  CSR read by IDU instruction
//  csr_ruse     in   1   instruction reads a CSR
//  csr_waddr    in   12  CSR written by IDU instruction
//  csr_wuse     in   1   instruction writes a CSR
//  wb_valid     in   1   retirement of one instruction this cycle
//  wb_rd        in   5   its GPR destination (0 = none)
//  wb_csr       in   1   it wrote the pending CSR
//  fwd1/fwd2    out  1   same-cycle writeback forward select for rs1/rs2
//  inflight     out  4   current in-flight count
// BEHAVIOUR
//  Reset (async): all GPR counters 0, csr_pend 0, inflight 0; hence idu_ready=exu_ready-gated, fwd1/2=0.
//  hazN = rsN_use & rsN!=0 & cnt[rsN]!=0 & ~(wb_valid & wb_rd==rsN & cnt[rsN]==1).
//  fwdN = rsN_use & rsN!=0 & wb_valid & wb_rd==rsN & cnt[rsN]==1 (last pending writer retiring now).
//  csr_haz = csr_pend & ((csr_ruse & csr_raddr==csr_paddr) | csr_wuse) & ~(wb_valid & wb_csr).
//  block = haz1|haz2|csr_haz|(rd!=0 & cnt[rd]==max & ~(wb_valid&wb_rd==rd))|(inflight==MAX_INFLIGHT & ~wb_valid).
//  exu_valid = idu_valid & ~flush & ~block; idu_ready = (exu_ready & ~block) | flush. Purely combinational, 0 latency.
//  issue = exu_valid & exu_ready. On issue: cnt[rd]++ if rd!=0; inflight++; if csr_wuse: csr_pend<=1, csr_paddr<=csr_waddr.
//  On wb_valid: cnt[wb_rd]-- if wb_rd!=0; inflight--; if wb_csr: csr_pend<=0.
//  Simultaneous issue+wb on same rd: cnt unchanged; inflight unchanged. issue csr_wuse + wb_csr: csr_pend stays 1, new addr.
//  x0 never tracked. wb on cnt==0 or inflight==0: counter holds at 0, simulation assertion fires.
//  flush never clears counters: everything already issued always retires.
//  Reset mid-operation drops all pending state in the same cycle; next cycle idu_ready follows exu_ready.
//  No combinational path from exu_ready to exu_valid.
// STRUCTURE
//  Constants/typedefs in shared include def/sb.sv: SB_MAX_INFLIGHT default, cnt_t, sb_req_t (rs/rd/csr bundle).
//  Sub-module ysyx_23060203_sb_cnt: one saturating up/down counter with inc, dec, zero, max, one flags;
//  instantiated 31x via generate (x1..x31) and 1x for inflight.
//  Perf events (non-SYNTHESIS): PERF_SB_STALL_GPR, PERF_SB_STALL_CSR, PERF_SB_STALL_FULL per blocked cycle.
// TESTING
//  1 load x5 issued, no wb; next add x6,x5,x1 -> exu_valid=0 until wb_rd=5; that cycle fwd1=1, exu_valid=1.
//  2 two lw x7 back-to-back, one wb_rd=7 -> cnt[7]=1, reader of x7 still blocked; 2nd wb -> unblocked.
//  3 rd=0 / rs1=0 instructions -> never block, counters stay 0; inflight still counts.
//  4 csrw mtvec pending, csrr mtvec -> blocked; csrr mstatus -> issues; csrw mepc -> blocked (single slot).
//  5 MAX_INFLIGHT=4 issued, none retired -> idu_ready=0; wb_valid same cycle -> 5th issues, inflight stays 4.
//  6 reset asserted with cnt[3]=2, inflight=3 -> all zero immediately; flush with idu_valid -> exu_valid=0, idu_ready=1.

Source files
------------

// File: rtl/ysyx_23060203_issue_sb_pkg.sv
// Shared constants and request bundle for the IDU->EXU issue scoreboard.
package ysyx_23060203_issue_sb_pkg;

   localparam int SB_MAX_INFLIGHT = 4;
   localparam int SB_CNT_W        = 2;
   localparam int SB_INFL_W       = 4;

   typedef logic [SB_CNT_W-1:0] cnt_t;

   // Operand/destination view of the instruction currently offered by IDU.
   typedef struct packed {
      logic [4:0]  rs1;
      logic        rs1Use;
      logic [4:0]  rs2;
      logic        rs2Use;
      logic [4:0]  rd;
      logic [11:0] csrRaddr;
      logic        csrRuse;
      logic [11:0] csrWaddr;
      logic        csrWuse;
   } sb_req_t;

endpackage

// File: rtl/ysyx_23060203_sb_cnt.sv
// Saturating up/down counter with zero/one/max flags; simultaneous inc and dec cancel.
module ysyx_23060203_sb_cnt #(
   parameter int W   = 2,
   parameter int MAX = 3
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         i_inc,
   input  logic         i_dec,
   output logic [W-1:0] o_count,
   output logic         o_zero,
   output logic         o_one,
   output logic         o_max
);

   logic [W-1:0] r_count;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_inc && !i_dec && r_count != W'(MAX)) begin
         r_count <= r_count + 1'b1;
      end else if (i_dec && !i_inc && r_count != '0) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_count = r_count;
   assign o_zero  = (r_count == '0);
   assign o_one   = (r_count == W'(1));
   assign o_max   = (r_count == W'(MAX));

`ifndef SYNTHESIS
   // A retirement with nothing outstanding means the EXU and the scoreboard disagree.
   always @(posedge clock) begin
      if (!reset && i_dec)
         assert (r_count != '0) else $error("sb_cnt: retirement against an empty counter");
   end
`endif

endmodule

// File: rtl/ysyx_23060203_issue_sb.sv
// Issue scoreboard: holds IDU instructions whose GPR/CSR operands are still owed by
// multi-cycle EXU work, and caps the number of issued-but-unretired instructions.
module ysyx_23060203_issue_sb
   import ysyx_23060203_issue_sb_pkg::*;
#(
   parameter int MAX_INFLIGHT = SB_MAX_INFLIGHT,
   parameter int CNT_W        = SB_CNT_W
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        idu_valid,
   output logic        idu_ready,
   output logic        exu_valid,
   input  logic        exu_ready,
   input  logic        flush,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic        rs1_use,
   input  logic        rs2_use,
   input  logic [4:0]  rd,
   input  logic [11:0] csr_raddr,
   input  logic        csr_ruse,
   input  logic [11:0] csr_waddr,
   input  logic        csr_wuse,
   input  logic        wb_valid,
   input  logic [4:0]  wb_rd,
   input  logic        wb_csr,
   output logic        fwd1,
   output logic        fwd2,
   output logic [3:0]  inflight
);

   sb_req_t                    w_req;
   logic [31:0]                w_gprZero;
   logic [31:0]                w_gprOne;
   logic [31:0]                w_gprMax;
   logic [31:1][CNT_W-1:0]     w_gprCnt;
   logic                       w_inflZero;
   logic                       w_inflOne;
   logic                       w_inflMax;
   logic                       w_hit1;
   logic                       w_hit2;
   logic                       w_haz1;
   logic                       w_haz2;
   logic                       w_waw;
   logic                       w_csrHaz;
   logic                       w_full;
   logic                       w_block;
   logic                       w_issue;
   logic                       w_unusedFlags;
   logic                       r_csrPend;
   logic [11:0]                r_csrPaddr;

   assign w_req = '{rs1: rs1, rs1Use: rs1_use, rs2: rs2, rs2Use: rs2_use, rd: rd,
                    csrRaddr: csr_raddr, csrRuse: csr_ruse,
                    csrWaddr: csr_waddr, csrWuse: csr_wuse};

   // x0 is never tracked: it reads as permanently idle.
   assign w_gprZero[0] = 1'b1;
   assign w_gprOne[0]  = 1'b0;
   assign w_gprMax[0]  = 1'b0;

   for (genvar i = 1; i < 32; i++) begin : g_gpr
      ysyx_23060203_sb_cnt #(.W(CNT_W), .MAX((1 << CNT_W) - 1)) u_cnt (
         .clock   (clock),
         .reset   (reset),
         .i_inc   (w_issue && w_req.rd == 5'(i)),
         .i_dec   (wb_valid && wb_rd == 5'(i)),
         .o_count (w_gprCnt[i]),
         .o_zero  (w_gprZero[i]),
         .o_one   (w_gprOne[i]),
         .o_max   (w_gprMax[i])
      );
   end

   ysyx_23060203_sb_cnt #(.W(SB_INFL_W), .MAX(MAX_INFLIGHT)) u_inflight (
      .clock   (clock),
      .reset   (reset),
      .i_inc   (w_issue),
      .i_dec   (wb_valid),
      .o_count (inflight),
      .o_zero  (w_inflZero),
      .o_one   (w_inflOne),
      .o_max   (w_inflMax)
   );

   assign w_unusedFlags = ^{w_gprCnt, w_inflZero, w_inflOne};

   // A source whose only outstanding writer retires this cycle is forwarded instead of stalled.
   assign w_hit1 = wb_valid && wb_rd == w_req.rs1;
   assign w_hit2 = wb_valid && wb_rd == w_req.rs2;
   assign fwd1   = w_req.rs1Use && w_req.rs1 != 5'd0 && w_hit1 && w_gprOne[w_req.rs1];
   assign fwd2   = w_req.rs2Use && w_req.rs2 != 5'd0 && w_hit2 && w_gprOne[w_req.rs2];
   assign w_haz1 = w_req.rs1Use && w_req.rs1 != 5'd0 && !w_gprZero[w_req.rs1]
                   && !(w_hit1 && w_gprOne[w_req.rs1]);
   assign w_haz2 = w_req.rs2Use && w_req.rs2 != 5'd0 && !w_gprZero[w_req.rs2]
                   && !(w_hit2 && w_gprOne[w_req.rs2]);

   assign w_csrHaz = r_csrPend
                     && ((w_req.csrRuse && w_req.csrRaddr == r_csrPaddr) || w_req.csrWuse)
                     && !(wb_valid && wb_csr);
   assign w_waw    = w_req.rd != 5'd0 && w_gprMax[w_req.rd] && !(wb_valid && wb_rd == w_req.rd);
   assign w_full   = w_inflMax && !wb_valid;
   assign w_block  = w_haz1 || w_haz2 || w_csrHaz || w_waw || w_full;

   // exu_valid deliberately ignores exu_ready so the handshake has no ready->valid loop.
   assign exu_valid = idu_valid && !flush && !w_block;
   assign idu_ready = (exu_ready && !w_block) || flush;
   assign w_issue   = exu_valid && exu_ready;

   // Single CSR slot; a new writer issuing as the old one retires takes the slot over.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_csrPend  <= 1'b0;
         r_csrPaddr <= '0;
      end else if (w_issue && w_req.csrWuse) begin
         r_csrPend  <= 1'b1;
         r_csrPaddr <= w_req.csrWaddr;
      end else if (wb_valid && wb_csr) begin
         r_csrPend  <= 1'b0;
      end
   end

`ifndef SYNTHESIS
   logic [31:0] r_perfSbStallGpr;
   logic [31:0] r_perfSbStallCsr;
   logic [31:0] r_perfSbStallFull;
   logic        w_stallQual;
   logic        w_unusedPerf;

   assign w_stallQual = idu_valid && !flush;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_perfSbStallGpr  <= '0;
         r_perfSbStallCsr  <= '0;
         r_perfSbStallFull <= '0;
      end else begin
         if (w_stallQual && (w_haz1 || w_haz2 || w_waw)) r_perfSbStallGpr  <= r_perfSbStallGpr + 1'b1;
         if (w_stallQual && w_csrHaz)                    r_perfSbStallCsr  <= r_perfSbStallCsr + 1'b1;
         if (w_stallQual && w_full)                      r_perfSbStallFull <= r_perfSbStallFull + 1'b1;
      end
   end

   assign w_unusedPerf = ^{r_perfSbStallGpr, r_perfSbStallCsr, r_perfSbStallFull};
`endif

endmodule

// File: tb/tb_ysyx_23060203_issue_sb.sv
// Bench for the issue scoreboard: directed vector table, hand-built reset/flush sequence,
// then randomized traffic against an in-order retirement-queue model.
module tb_ysyx_23060203_issue_sb;

   logic        clock = 1'b0;
   logic        reset;
   logic        idu_valid, idu_ready, exu_valid, exu_ready, flush;
   logic [4:0]  rs1, rs2, rd, wb_rd;
   logic        rs1_use, rs2_use;
   logic [11:0] csr_raddr, csr_waddr;
   logic        csr_ruse, csr_wuse;
   logic        wb_valid, wb_csr;
   logic        fwd1, fwd2;
   logic [3:0]  inflight;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        iv, er, fl;
      logic [4:0]  rs1;
      logic        u1;
      logic [4:0]  rs2;
      logic        u2;
      logic [4:0]  rd;
      logic [11:0] cra;
      logic        cru;
      logic [11:0] cwa;
      logic        cwu;
      logic        wbv;
      logic [4:0]  wbr;
      logic        wbc;
      logic        eEv, eIr, eF1, eF2;
      int          eInfl;
   } vec_t;

   typedef struct {
      int rd;
      bit csrw;
   } ent_t;

   vec_t vecs[$];
   int   mCnt[32];
   ent_t mQ[$];
   bit   mCsrPend;
   int   mCsrAddr;

   ysyx_23060203_issue_sb dut (
      .clock     (clock),
      .reset     (reset),
      .idu_valid (idu_valid),
      .idu_ready (idu_ready),
      .exu_valid (exu_valid),
      .exu_ready (exu_ready),
      .flush     (flush),
      .rs1       (rs1),
      .rs2       (rs2),
      .rs1_use   (rs1_use),
      .rs2_use   (rs2_use),
      .rd        (rd),
      .csr_raddr (csr_raddr),
      .csr_ruse  (csr_ruse),
      .csr_waddr (csr_waddr),
      .csr_wuse  (csr_wuse),
      .wb_valid  (wb_valid),
      .wb_rd     (wb_rd),
      .wb_csr    (wb_csr),
      .fwd1      (fwd1),
      .fwd2      (fwd2),
      .inflight  (inflight)
   );

   always #5 clock = ~clock;

   function automatic vec_t mkGpr(input logic iv, input logic er, input logic [4:0] r1, input logic u1,
                                  input logic [4:0] r2, input logic u2, input logic [4:0] d,
                                  input logic wbv, input logic [4:0] wbr,
                                  input logic eEv, input logic eIr, input logic eF1, input logic eF2,
                                  input int eInfl);
      vec_t v;
      v = '{iv: iv, er: er, fl: 1'b0, rs1: r1, u1: u1, rs2: r2, u2: u2, rd: d,
            cra: 12'h0, cru: 1'b0, cwa: 12'h0, cwu: 1'b0, wbv: wbv, wbr: wbr, wbc: 1'b0,
            eEv: eEv, eIr: eIr, eF1: eF1, eF2: eF2, eInfl: eInfl};
      return v;
   endfunction

   function automatic vec_t mkCsr(input logic iv, input logic [4:0] d, input logic [11:0] cra, input logic cru,
                                  input logic [11:0] cwa, input logic cwu, input logic wbv,
                                  input logic [4:0] wbr, input logic wbc,
                                  input logic eEv, input logic eIr, input int eInfl);
      vec_t v;
      v = mkGpr(iv, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, d, wbv, wbr, eEv, eIr, 1'b0, 1'b0, eInfl);
      v.cra = cra; v.cru = cru; v.cwa = cwa; v.cwu = cwu; v.wbc = wbc;
      return v;
   endfunction

   task automatic driveInputs(input vec_t v);
      idu_valid = v.iv;  exu_ready = v.er;  flush = v.fl;
      rs1 = v.rs1;  rs1_use = v.u1;  rs2 = v.rs2;  rs2_use = v.u2;  rd = v.rd;
      csr_raddr = v.cra;  csr_ruse = v.cru;  csr_waddr = v.cwa;  csr_wuse = v.cwu;
      wb_valid = v.wbv;  wb_rd = v.wbr;  wb_csr = v.wbc;
   endtask

   // Inputs change on the falling edge; outputs are sampled 1ns later, well clear of the rising edge.
   task automatic applyStimulus(input vec_t v);
      @(negedge clock);
      driveInputs(v);
      #1;
   endtask

   task automatic cmp(input string name, input string field, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s %s: got %0d expected %0d", name, field, act, exp);
      end
   endtask

   task automatic checkOutput(input string name, input vec_t v);
      cmp(name, "exu_valid", int'(exu_valid), int'(v.eEv));
      cmp(name, "idu_ready", int'(idu_ready), int'(v.eIr));
      cmp(name, "fwd1",      int'(fwd1),      int'(v.eF1));
      cmp(name, "fwd2",      int'(fwd2),      int'(v.eF2));
      cmp(name, "inflight",  int'(inflight),  v.eInfl);
   endtask

   task automatic doReset();
      vec_t idle;
      idle = mkGpr(1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
      driveInputs(idle);
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      foreach (mCnt[i]) mCnt[i] = 0;
      mQ.delete();
      mCsrPend = 1'b0;
      mCsrAddr = 0;
   endtask

   // Reference model: one pending count per register, a FIFO of unretired instructions,
   // and one outstanding CSR write.
   task automatic modelExpect(inout vec_t v);
      bit lastW1, lastW2, waiting1, waiting2, csrBlk, waw, full, blk;
      lastW1   = v.wbv && v.wbr == v.rs1 && mCnt[v.rs1] == 1;
      lastW2   = v.wbv && v.wbr == v.rs2 && mCnt[v.rs2] == 1;
      waiting1 = v.u1 && v.rs1 != 0 && mCnt[v.rs1] > 0 && !lastW1;
      waiting2 = v.u2 && v.rs2 != 0 && mCnt[v.rs2] > 0 && !lastW2;
      csrBlk   = mCsrPend && ((v.cru && int'(v.cra) == mCsrAddr) || v.cwu) && !(v.wbv && v.wbc);
      waw      = v.rd != 0 && mCnt[v.rd] == 3 && !(v.wbv && v.wbr == v.rd);
      full     = mQ.size() == 4 && !v.wbv;
      blk      = waiting1 || waiting2 || csrBlk || waw || full;
      v.eEv    = v.iv && !v.fl && !blk;
      v.eIr    = (v.er && !blk) || v.fl;
      v.eF1    = v.u1 && v.rs1 != 0 && lastW1;
      v.eF2    = v.u2 && v.rs2 != 0 && lastW2;
      v.eInfl  = mQ.size();
   endtask

   task automatic modelStep(input vec_t v);
      ent_t e;
      if (v.wbv) begin
         e = mQ.pop_front();
         if (e.rd != 0) mCnt[e.rd]--;
         if (e.csrw) mCsrPend = 1'b0;
      end
      if (v.eEv && v.er) begin
         mQ.push_back('{rd: int'(v.rd), csrw: v.cwu});
         if (v.rd != 0) mCnt[v.rd]++;
         if (v.cwu) begin
            mCsrPend = 1'b1;
            mCsrAddr = int'(v.cwa);
         end
      end
   endtask

   task automatic randomVec(output vec_t v);
      logic [11:0] addrs[2];
      addrs[0] = 12'h300;
      addrs[1] = 12'h305;
      v = mkGpr($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0,
                5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 5)), 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
      v.fl  = $urandom_range(0, 9) == 0;
      v.cru = $urandom_range(0, 9) < 3;
      v.cra = addrs[$urandom_range(0, 1)];
      v.cwu = $urandom_range(0, 9) < 2;
      v.cwa = addrs[$urandom_range(0, 1)];
      if (mQ.size() > 0 && $urandom_range(0, 1) == 1) begin
         v.wbv = 1'b1;
         v.wbr = 5'(mQ[0].rd);
         v.wbc = mQ[0].csrw;
      end
   endtask

   task automatic resetMidOp();
      vec_t v;
      v = mkGpr(1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 0);
      applyStimulus(v);
      v.eInfl = 1; applyStimulus(v); checkOutput("seq_x3_second", v);
      v.rd = 5'd4; v.eInfl = 2; applyStimulus(v); checkOutput("seq_x4", v);
      v = mkGpr(1'b1, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
      applyStimulus(v); checkOutput("seq_reader_blocked", v);
      flush = 1'b1; #1;
      v.eIr = 1'b1; checkOutput("seq_flush", v);
      flush = 1'b0; #1;
      v.eIr = 1'b0; checkOutput("seq_after_flush", v);
      reset = 1'b1; #1;
      v.eEv = 1'b1; v.eIr = 1'b1; v.eInfl = 0; checkOutput("seq_in_reset", v);
      idu_valid = 1'b0;
      @(negedge clock);
      reset = 1'b0; exu_ready = 1'b0; #1;
      cmp("seq_post_reset_er0", "idu_ready", int'(idu_ready), 0);
      exu_ready = 1'b1; #1;
      cmp("seq_post_reset_er1", "idu_ready", int'(idu_ready), 1);
      idu_valid = 1'b1; #1;
      v.eEv = 1'b1; v.eIr = 1'b1; checkOutput("seq_x3_cleared", v);
      idu_valid = 1'b0;
   endtask

   initial begin
      vec_t v;
      reset = 1'b1;
      doReset();

      vecs.push_back(mkGpr(0,1, 0,0, 0,0, 0, 0,0,  0,1,0,0, 0));
      vecs.push_back(mkGpr(1,1, 2,1, 0,0, 5, 0,0,  1,1,0,0, 0));
      vecs.push_back(mkGpr(1,1, 5,1, 1,1, 6, 0,0,  0,0,0,0, 1));
      vecs.push_back(mkGpr(1,1, 5,1, 1,1, 6, 0,0,  0,0,0,0, 1));
      vecs.push_back(mkGpr(1,1, 5,1, 1,1, 6, 1,5,  1,1,1,0, 1));
      vecs.push_back(mkGpr(0,1, 0,0, 0,0, 0, 1,6,  0,1,0,0, 1));
      vecs.push_back(mkGpr(1,1, 2,1, 0,0, 7, 0,0,  1,1,0,0, 0));
      vecs.push_back(mkGpr(1,1, 2,1, 0,0, 7, 0,0,  1,1,0,0, 1));
      vecs.push_back(mkGpr(1,1, 0,0, 7,1, 8, 1,7,  0,0,0,0, 2));
      vecs.push_back(mkGpr(1,1, 0,0, 7,1, 8, 0,0,  0,0,0,0, 1));
      vecs.push_back(mkGpr(1,1, 0,0, 7,1, 8, 1,7,  1,1,0,1, 1));
      vecs.push_back(mkGpr(0,1, 0,0, 0,0, 0, 1,8,  0,1,0,0, 1));
      vecs.push_back(mkGpr(1,1, 0,1, 0,1, 0, 0,0,  1,1,0,0, 0));
      vecs.push_back(mkGpr(1,1, 0,1, 0,1, 0, 0,0,  1,1,0,0, 1));
      vecs.push_back(mkGpr(0,1, 0,0, 0,0, 0, 1,0,  0,1,0,0, 2));
      vecs.push_back(mkGpr(0,1, 0,0, 0,0, 0, 1,0,  0,1,0,0, 1));
      vecs.push_back(mkCsr(1, 0,  12'h000,0, 12'h305,1, 0,0,0,   1,1,0));
      vecs.push_back(mkCsr(1, 10, 12'h305,1, 12'h000,0, 0,0,0,   0,0,1));
      vecs.push_back(mkCsr(1, 10, 12'h300,1, 12'h000,0, 0,0,0,   1,1,1));
      vecs.push_back(mkCsr(1, 0,  12'h000,0, 12'h341,1, 0,0,0,   0,0,2));
      vecs.push_back(mkCsr(1, 0,  12'h000,0, 12'h341,1, 1,0,1,   1,1,2));
      vecs.push_back(mkCsr(1, 0,  12'h305,1, 12'h000,0, 0,0,0,   1,1,2));
      vecs.push_back(mkCsr(1, 0,  12'h341,1, 12'h000,0, 0,0,0,   0,0,3));
      vecs.push_back(mkCsr(0, 0,  12'h000,0, 12'h000,0, 1,10,0,  0,1,3));
      vecs.push_back(mkCsr(0, 0,  12'h000,0, 12'h000,0, 1,0,1,   0,1,2));
      vecs.push_back(mkCsr(0, 0,  12'h000,0, 12'h000,0, 1,0,0,   0,1,1));
      for (int k = 0; k < 4; k++) vecs.push_back(mkGpr(1,1, 0,0, 0,0, 0, 0,0, 1,1,0,0, k));
      vecs.push_back(mkGpr(1,1, 0,0, 0,0, 0, 0,0,  0,0,0,0, 4));
      vecs.push_back(mkGpr(1,1, 0,0, 0,0, 0, 1,0,  1,1,0,0, 4));
      vecs.push_back(mkGpr(1,0, 0,0, 0,0, 0, 1,0,  1,0,0,0, 4));
      for (int k = 3; k > 0; k--) vecs.push_back(mkGpr(0,1, 0,0, 0,0, 0, 1,0, 0,1,0,0, k));
      for (int k = 0; k < 3; k++) vecs.push_back(mkGpr(1,1, 0,0, 0,0, 9, 0,0, 1,1,0,0, k));
      vecs.push_back(mkGpr(1,1, 0,0, 0,0, 9, 0,0,  0,0,0,0, 3));
      vecs.push_back(mkGpr(1,1, 0,0, 0,0, 9, 1,9,  1,1,0,0, 3));
      vecs.push_back(mkGpr(1,1, 9,1, 0,0, 0, 1,9,  0,0,0,0, 3));
      for (int k = 2; k > 0; k--) vecs.push_back(mkGpr(0,1, 0,0, 0,0, 0, 1,9, 0,1,0,0, k));
      v = mkGpr(1,0, 0,0, 0,0, 0, 0,0,  0,1,0,0, 0);
      v.fl = 1'b1;
      vecs.push_back(v);

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("vec%0d", i), vecs[i]);
      end

      resetMidOp();

      doReset();
      for (int n = 0; n < 3000; n++) begin
         randomVec(v);
         modelExpect(v);
         applyStimulus(v);
         checkOutput($sformatf("rand%0d", n), v);
         modelStep(v);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
